// File: rtl/mult_seq_if.sv
// rtl/mult_seq_if.sv - request/response bundle for the sequential multiplier
interface mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic                   abort;
  logic                   signed_mode;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic [2*WIDTH-1:0]     Result;
  logic                   done;
  logic                   busy;
  logic                   Z;
  logic                   OV;
  logic                   NEG;

  modport master (
    output start, abort, signed_mode, A, B,
    input  Result, done, busy, Z, OV, NEG
  );

  modport slave (
    input  start, abort, signed_mode, A, B,
    output Result, done, busy, Z, OV, NEG
  );
endinterface

// File: rtl/mult_seq_param.sv
// rtl/mult_seq_param.sv - parametrised shift-add multiplier, sign-magnitude core
module mult_seq_param #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  mult_seq_if.slave  bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state_q, state_d;
  logic [W2-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic              mode_q, mode_d;
  logic [W2-1:0]     result_q, result_d;
  logic              z_q, z_d;
  logic              ov_q, ov_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  a_mag, b_mag, mplier_nxt;
  logic [W2-1:0]     acc_sum, res;
  logic              last;

  // Magnitude of -2^(WIDTH-1) wraps to itself, which is the correct unsigned value.
  assign a_mag      = (bus.signed_mode && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign b_mag      = (bus.signed_mode && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mplier_nxt = mplier_q >> 1;
  assign res        = sign_q ? -acc_q : acc_q;
  assign last       = (cnt_q == CW'(WIDTH - 1)) || (EARLY_EXIT && (mplier_nxt == '0));

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    mode_d   = mode_q;
    result_d = result_q;
    z_d      = z_q;
    ov_d     = ov_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          sign_d   = bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
          mode_d   = bus.signed_mode;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_nxt;
          cnt_d    = cnt_q + CW'(1);
          if (last) state_d = FIX;
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!bus.abort) begin
          result_d = res;
          z_d      = (res == '0);
          // Signed fit means the top WIDTH+1 bits are pure sign extension.
          ov_d     = mode_q ? !((&res[W2-1:WIDTH-1]) || !(|res[W2-1:WIDTH-1]))
                            : (|res[W2-1:WIDTH]);
          neg_d    = mode_q & res[W2-1];
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      mode_q   <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
      ov_q     <= 1'b0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      z_q      <= z_d;
      ov_q     <= ov_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.Result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.Z      = z_q;
  assign bus.OV     = ov_q;
  assign bus.NEG    = neg_q;
endmodule

// File: tb/tb_mult_seq_param.sv
// tb/tb_mult_seq_param.sv - scoreboard bench for fixed and early-exit multipliers
module tb_mult_seq_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mult_seq_if #(.WIDTH(8)) bus0 ();
  mult_seq_if #(.WIDTH(8)) bus1 ();

  mult_seq_param #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_fixed (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mult_seq_param #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_early (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        ov;
    logic        neg;
    int          t_done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus0.done === 1'b1) begin
      if (q0.size() == 0) begin
        n_chk++;
        $display("FAIL dut0 spurious done at edge %0d: done=1 expected 0", cyc);
      end else begin
        e0 = q0.pop_front();
        chk("dut0 result", 32'(bus0.Result), 32'(e0.res));
        chk("dut0 Z", 32'(bus0.Z), 32'(e0.z));
        chk("dut0 OV", 32'(bus0.OV), 32'(e0.ov));
        chk("dut0 NEG", 32'(bus0.NEG), 32'(e0.neg));
        chk("dut0 done edge", 32'(cyc), 32'(e0.t_done));
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.done === 1'b1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL dut1 spurious done at edge %0d: done=1 expected 0", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 result", 32'(bus1.Result), 32'(e1.res));
        chk("dut1 Z", 32'(bus1.Z), 32'(e1.z));
        chk("dut1 OV", 32'(bus1.OV), 32'(e1.ov));
        chk("dut1 NEG", 32'(bus1.NEG), 32'(e1.neg));
        chk("dut1 done edge", 32'(cyc), 32'(e1.t_done));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [15:0] r, input logic z, input logic ov, input logic neg,
                       input int lat, input bit expect_it);
    exp_t e;
    e.res = r; e.z = z; e.ov = ov; e.neg = neg; e.t_done = cyc + 1 + lat;
    if (expect_it) begin
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (d == 0) begin
      bus0.A = a; bus0.B = b; bus0.signed_mode = sm; bus0.start = 1'b1;
    end else begin
      bus1.A = a; bus1.B = b; bus1.signed_mode = sm; bus1.start = 1'b1;
    end
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.signed_mode = 1'b0; bus0.A = '0; bus0.B = '0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.signed_mode = 1'b0; bus1.A = '0; bus1.B = '0;
    repeat (2) @(negedge clk);
    chk("reset Result", 32'(bus0.Result), 32'd0);
    chk("reset busy", 32'(bus0.busy), 32'd0);
    chk("reset done", 32'(bus0.done), 32'd0);
    chk("reset Z/OV/NEG", 32'({bus0.Z, bus0.OV, bus0.NEG}), 32'd0);
    chk("reset dut1 Result", 32'(bus1.Result), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed latency, with an ignored start pulse while busy
    issue(0, 8'd13, 8'd11, 1'b0, 16'h008F, 1'b0, 1'b0, 1'b0, 9, 1'b1);
    chk("busy after accept", 32'(bus0.busy), 32'd1);
    repeat (2) @(negedge clk);
    bus0.A = 8'd1; bus0.B = 8'd1; bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("busy low after done", 32'(bus0.busy), 32'd0);

    issue(0, 8'd200, 8'd200, 1'b0, 16'h9C40, 1'b0, 1'b1, 1'b0, 9, 1'b1);
    repeat (10) @(negedge clk);
    issue(0, 8'hFD, 8'd5, 1'b1, 16'hFFF1, 1'b0, 1'b0, 1'b1, 9, 1'b1);
    repeat (10) @(negedge clk);
    issue(0, 8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, 1'b1, 1'b0, 9, 1'b1);
    repeat (10) @(negedge clk);

    // Abort mid-run keeps the previous Result and flags
    issue(0, 8'd7, 8'd9, 1'b0, 16'd63, 1'b0, 1'b0, 1'b0, 9, 1'b0);
    repeat (4) @(negedge clk);
    bus0.abort = 1'b1;
    chk("busy before abort", 32'(bus0.busy), 32'd1);
    @(negedge clk);
    bus0.abort = 1'b0;
    chk("busy after abort", 32'(bus0.busy), 32'd0);
    chk("done after abort", 32'(bus0.done), 32'd0);
    repeat (8) @(negedge clk);
    chk("Result held after abort", 32'(bus0.Result), 32'h4000);
    chk("OV held after abort", 32'(bus0.OV), 32'd1);

    // Abort in IDLE blocks start
    bus0.A = 8'd2; bus0.B = 8'd2; bus0.start = 1'b1; bus0.abort = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0; bus0.abort = 1'b0;
    chk("abort blocks start", 32'(bus0.busy), 32'd0);
    @(negedge clk);

    // Back-to-back start in the done cycle
    issue(0, 8'd6, 8'd7, 1'b0, 16'd42, 1'b0, 1'b0, 1'b0, 9, 1'b1);
    repeat (9) @(negedge clk);
    chk("done cycle reached", 32'(bus0.done), 32'd1);
    issue(0, 8'd3, 8'd3, 1'b0, 16'd9, 1'b0, 1'b0, 1'b0, 9, 1'b1);
    chk("b2b accepted", 32'(bus0.busy), 32'd1);
    repeat (10) @(negedge clk);

    // Reset mid-run clears outputs at once
    issue(0, 8'd100, 8'd100, 1'b0, 16'd10000, 1'b0, 1'b1, 1'b0, 9, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset Result", 32'(bus0.Result), 32'd0);
    chk("async reset busy", 32'(bus0.busy), 32'd0);
    chk("async reset flags", 32'({bus0.done, bus0.Z, bus0.OV, bus0.NEG}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 8'd255, 8'd255, 1'b0, 16'hFE01, 1'b0, 1'b1, 1'b0, 9, 1'b1);
    repeat (10) @(negedge clk);

    // Early exit latencies
    issue(1, 8'd77, 8'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 2, 1'b1);
    repeat (4) @(negedge clk);
    issue(1, 8'd5, 8'd3, 1'b0, 16'd15, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    repeat (5) @(negedge clk);
    issue(1, 8'd13, 8'd11, 1'b0, 16'h008F, 1'b0, 1'b0, 1'b0, 5, 1'b1);
    repeat (7) @(negedge clk);
    issue(1, 8'hFD, 8'd5, 1'b1, 16'hFFF1, 1'b0, 1'b0, 1'b1, 4, 1'b1);
    repeat (6) @(negedge clk);

    chk("dut0 all done pulses seen", 32'(q0.size()), 32'd0);
    chk("dut1 all done pulses seen", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
